// File: rtl/store_image_if.sv
// Bus bundle between the feature-map write-back engine and its client/memory side.
// master: the side that requests stores and acknowledges blocks.
// slave:  the store engine itself.
interface store_image_if #(
  parameter int MEM_ADDR_SIZE  = 32,
  parameter int BLOCK_SIZE     = 150,
  parameter int DATA_SIZE      = 16,
  parameter int IMG_SIZE_WIDTH = 6,
  parameter int MAX_PIXELS     = 1024
);
  logic                      start;
  logic [IMG_SIZE_WIDTH-1:0] imgSize;
  logic [MEM_ADDR_SIZE-1:0]  initialAddr;
  logic [DATA_SIZE-1:0]      image [0:MAX_PIXELS-1];
  logic                      memAck;
  logic                      write;
  logic [MEM_ADDR_SIZE-1:0]  address;
  logic [DATA_SIZE-1:0]      out [0:BLOCK_SIZE-1];
  logic [7:0]                validCount;
  logic                      busy;
  logic                      done;

  modport master (
    output start, imgSize, initialAddr, image, memAck,
    input  write, address, out, validCount, busy, done
  );

  modport slave (
    input  start, imgSize, initialAddr, image, memAck,
    output write, address, out, validCount, busy, done
  );
endinterface

// File: rtl/store_image.sv
// Feature-map write-back: drains the source buffer to memory in BLOCK_SIZE-word
// blocks with incrementing addresses and a write/ack handshake. The block count
// is the exact ceiling of total/BLOCK_SIZE; the tail of the last block is zeroed.
module store_image #(
  parameter int MEM_ADDR_SIZE  = 32,
  parameter int BLOCK_SIZE     = 150,
  parameter int DATA_SIZE      = 16,
  parameter int IMG_SIZE_WIDTH = 6,
  parameter int MAX_PIXELS     = 1024
) (
  input logic          clk,
  input logic          rst,
  store_image_if.slave bus
);
  localparam int PIX_W = $clog2(MAX_PIXELS);
  localparam int TOT_W = $clog2(MAX_PIXELS + 1);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                    state_q, state_d;
  logic [3:0]                k_q, k_d;
  logic [TOT_W-1:0]          total_q, total_d, start_total;
  logic [MEM_ADDR_SIZE-1:0]  base_q, base_d, addr_d;
  logic                      load;
  logic                      last_block;
  logic [IMG_SIZE_WIDTH-1:0] side;
  logic [11:0]               side_sq;
  logic [15:0]               blk_start, remaining;
  logic [7:0]                vc_d;
  logic [DATA_SIZE-1:0]      out_d [0:BLOCK_SIZE-1];

  // Pixel count of the requested image, squared at 12 bits and clamped to the buffer depth.
  assign side        = bus.imgSize;
  assign side_sq     = 12'(side) * 12'(side);
  assign start_total = (side_sq > 12'(MAX_PIXELS)) ? TOT_W'(MAX_PIXELS) : side_sq[TOT_W-1:0];

  // The current block is the last one once its end reaches the pixel count.
  assign last_block = (16'(k_q) * 16'(BLOCK_SIZE) + 16'(BLOCK_SIZE)) >= 16'(total_q);

  // State register and transfer context.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      total_q <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      total_q <= total_d;
      base_q  <= base_d;
    end
  end

  // Next-state logic: accept start in IDLE, advance blocks on memAck, single-cycle DONE.
  // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    total_d = total_q;
    base_d  = base_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          k_d     = '0;
          total_d = start_total;
          base_d  = bus.initialAddr;
          state_d = (start_total == '0) ? DONE : WRITE;
        end
      end
      WRITE: begin
        if (bus.memAck) begin
          if (last_block) begin
            state_d = DONE;
          end else begin
            load = 1'b1;
            k_d  = k_q + 4'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Contents of the block about to be presented (block k_d of the pending transfer).
  assign blk_start = 16'(k_d) * 16'(BLOCK_SIZE);
  assign remaining = 16'(total_d) - blk_start;
  assign addr_d    = base_d + MEM_ADDR_SIZE'(blk_start);
  assign vc_d      = (remaining > 16'(BLOCK_SIZE)) ? 8'(BLOCK_SIZE) : remaining[7:0];

  for (genvar j = 0; j < BLOCK_SIZE; j++) begin : g_word
    logic [15:0] idx;
    assign idx      = blk_start + 16'(j);
    // Words past the pixel count are zero; the truncated index never leaves the buffer.
    assign out_d[j] = (idx < 16'(total_d)) ? bus.image[idx[PIX_W-1:0]] : '0;
  end

  // Block output registers: load on accepted start or block advance, otherwise hold.
  // NOTE: the output word array is a register bank, not a RAM, so it is cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.address    <= '0;
      bus.validCount <= '0;
      for (int j = 0; j < BLOCK_SIZE; j++) bus.out[j] <= '0;
    end else if (load) begin
      bus.address    <= addr_d;
      bus.validCount <= vc_d;
      for (int j = 0; j < BLOCK_SIZE; j++) bus.out[j] <= out_d[j];
    end
  end

  assign bus.write = (state_q == WRITE);
  assign bus.done  = (state_q == DONE);
  assign bus.busy  = (state_q != IDLE);
endmodule

// File: tb/tb_store_image.sv
// Self-checking bench for store_image: a block-list model built from the pixel
// count is compared every cycle, plus directed literal expectations per scenario.
module tb_store_image;
  localparam int BS = 150;
  localparam int NP = 1024;

  typedef struct {
    logic [31:0] addr;
    int          vc;
    int          first;
    int          total;
  } blk_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  store_image_if bus();

  store_image dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [15:0] img [0:NP-1];
  int n_pass = 0;
  int n_total = 0;

  blk_t q[$];
  blk_t last;
  bit   have_last = 1'b1;
  bit   done_flag = 1'b0;

  int          done_at;
  int          writes_seen;
  logic [31:0] addrs[$];
  int          vcs[$];
  int          exp_tab [0:6] = '{0, 150, 300, 450, 600, 750, 900};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] exp_word(input blk_t b, input int j);
    return (b.first + j < b.total) ? img[b.first + j] : 16'h0;
  endfunction

  function automatic logic [31:0] qa(input int i);
    return (i < addrs.size()) ? addrs[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic int qv(input int i);
    return (i < vcs.size()) ? vcs[i] : -1;
  endfunction

  task automatic build(input int sz, input logic [31:0] base);
    int   total;
    blk_t b;
    total = sz * sz;
    if (total > NP) total = NP;
    q.delete();
    for (int first = 0; first < total; first += BS) begin
      b.addr  = base + 32'(first);
      b.first = first;
      b.total = total;
      b.vc    = (total - first < BS) ? total - first : BS;
      q.push_back(b);
    end
  endtask

  task automatic cmp_block(input string tag, input blk_t b);
    int bad;
    bad = -1;
    for (int j = 0; j < BS; j++)
      if (bus.out[j] !== exp_word(b, j) && bad < 0) bad = j;
    if (bad < 0) bad = 0;
    check({tag, "_addr"}, bus.address, b.addr);
    check({tag, "_vc"}, bus.validCount, b.vc);
    check($sformatf("%s_out[%0d]", tag, bad), bus.out[bad], exp_word(b, bad));
  endtask

  // Model compare: expected outputs for the current cycle, then advance on the inputs.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      done_flag  = 1'b0;
      have_last  = 1'b1;
      last.addr  = '0;
      last.vc    = 0;
      last.first = 0;
      last.total = 0;
      check("rst_ctrl", {bus.write, bus.busy, bus.done}, 3'b000);
      cmp_block("rst", last);
    end else begin
      bit ew;
      ew = (q.size() > 0);
      check("ctrl", {bus.write, bus.busy, bus.done}, {ew, ew | done_flag, done_flag});
      if (ew) cmp_block("blk", q[0]);
      else if (have_last) cmp_block("hold", last);
      if (done_flag) begin
        done_flag = 1'b0;
      end else if (ew) begin
        if (bus.memAck) begin
          last      = q.pop_front();
          have_last = 1'b1;
          if (q.size() == 0) done_flag = 1'b1;
        end
      end else if (bus.start) begin
        build(int'(bus.imgSize), bus.initialAddr);
        if (q.size() == 0) begin
          done_flag = 1'b1;
          have_last = 1'b0;
        end
      end
    end
  end

  // One store transaction; entered and left at posedge+1.
  task automatic run(input int sz, input logic [31:0] base, input int stall_blk, input int stall_len,
                     input logic [31:0] stall_addr, input int pulse_blk, input int rst_blk);
    int acked, stalls, dpulses;
    bit pulsed;
    acked = 0; stalls = 0; pulsed = 1'b0; done_at = -1; writes_seen = 0;
    addrs.delete();
    vcs.delete();
    bus.imgSize     = 6'(sz);
    bus.initialAddr = base;
    bus.start       = 1'b1;
    bus.memAck      = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 60 && done_at < 0; c++) begin
      bus.memAck = 1'b1;
      bus.start  = 1'b0;
      if (bus.write && acked == rst_blk) begin
        #2 rst = 1'b1;
        #1;
        check("rst_async_write", bus.write, 1'b0);
        check("rst_async_busy", bus.busy, 1'b0);
        check("rst_async_done", bus.done, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        dpulses = 0;
        repeat (10) begin
          @(negedge clk);
          if (bus.done) dpulses++;
          @(posedge clk); #1;
        end
        check("rst_no_done", dpulses, 0);
        return;
      end
      if (bus.write && acked == stall_blk && stalls < stall_len) begin
        bus.memAck = 1'b0;
        stalls++;
      end
      if (bus.write && acked == pulse_blk && !pulsed) begin
        bus.start   = 1'b1;
        bus.imgSize = 6'd10;
        pulsed      = 1'b1;
      end
      @(negedge clk);
      if (bus.write) writes_seen++;
      if (bus.write && !bus.memAck) check("stall_addr", bus.address, stall_addr);
      if (bus.write && bus.memAck) begin
        addrs.push_back(bus.address);
        vcs.push_back(int'(bus.validCount));
        acked++;
      end
      if (bus.done) done_at = c;
      @(posedge clk); #1;
    end
    check("done_seen", (done_at >= 0) ? 1 : 0, 1);
  endtask

  task automatic check_seven(input string tag);
    check({tag, "_nblocks"}, addrs.size(), 7);
    for (int i = 0; i < 7; i++) check($sformatf("%s_addr%0d", tag, i), qa(i), exp_tab[i]);
    check({tag, "_vc0"}, qv(0), 150);
    check({tag, "_vc6"}, qv(6), 124);
  endtask

  initial begin
    int idle_writes;
    for (int i = 0; i < NP; i++) begin
      img[i]       = 16'(i * 37 + 5) ^ 16'h5A00;
      bus.image[i] = img[i];
    end
    bus.start       = 1'b0;
    bus.imgSize     = '0;
    bus.initialAddr = '0;
    bus.memAck      = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_write", bus.write, 1'b0);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_addr", bus.address, 32'h0);
    check("reset_vc", bus.validCount, 8'd0);
    check("reset_out0", bus.out[0], 16'h0);

    // Single partial block.
    run(10, 32'h1000, -1, 0, 32'h0, -1, -1);
    check("t1_done_at", done_at, 2);
    check("t1_nblocks", addrs.size(), 1);
    check("t1_addr", bus.address, 32'h1000);
    check("t1_vc", bus.validCount, 8'd100);
    check("t1_out99", bus.out[99], img[99]);
    check("t1_out100", bus.out[100], 16'h0);
    check("t1_out149", bus.out[149], 16'h0);

    // Full buffer, seven blocks.
    run(32, 32'h0, -1, 0, 32'h0, -1, -1);
    check("t2_done_at", done_at, 8);
    check_seven("t2");
    check("t2_out123", bus.out[123], img[1023]);
    check("t2_out124", bus.out[124], 16'h0);

    // Three-cycle stall on block 2.
    run(32, 32'h0, 2, 3, 32'd300, -1, -1);
    check("t3_done_at", done_at, 11);
    check_seven("t3");

    // Empty image: no write at all.
    run(0, 32'h2000, -1, 0, 32'h0, -1, -1);
    check("t4_done_at", done_at, 1);
    check("t4_writes", writes_seen, 0);

    // Saturated pixel count.
    run(40, 32'h0, -1, 0, 32'h0, -1, -1);
    check("t5_done_at", done_at, 8);
    check_seven("t5");

    // Start pulsed mid-transfer is ignored.
    run(32, 32'h0, -1, 0, 32'h0, 3, -1);
    check("t6_done_at", done_at, 8);
    check_seven("t6");
    idle_writes = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.write) idle_writes++;
      @(posedge clk); #1;
    end
    check("t6_no_extra", idle_writes, 0);

    // Reset during block 4.
    run(32, 32'h0, -1, 0, 32'h0, -1, 4);
    check("t7_acked", addrs.size(), 4);

    // Fresh start after reset, with address wrap.
    run(32, 32'hFFFF_FF00, -1, 0, 32'h0, -1, -1);
    check("t8_done_at", done_at, 8);
    check("t8_nblocks", addrs.size(), 7);
    check("t8_addr1", qa(1), 32'hFFFF_FF96);
    check("t8_addr2", qa(2), 32'h0000_002C);
    check("t8_addr6", qa(6), 32'h0000_0284);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
    $fatal(1);
  end
endmodule
